vx_commit_arb: RTL and testbench
================================

Name: vx_commit_arb

Overview:
- Consumer end of the execute-unit commit interface: collects completions from all functional units (alu, lsu, csr, mul, fpu, gpu) onto one registered writeback port.
- Also produces the per-retire event and the running instret count consumed by the CSR unit.
- Sits between the execute stage and the register-file writeback / CSR perf logic.

Parameters:
- NUM_UNITS, 6, number of commit sources; unit index i occupies slice i of every packed input bus.
- NUM_THREADS, 4, threads per warp.
- NW_BITS, 2, warp-id width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cmt_valid  in  NUM_UNITS  per-unit commit valid.
- cmt_ready  out  NUM_UNITS  per-unit accept.
- cmt_wid  in  NUM_UNITS*NW_BITS  warp id.
- cmt_pc  in  NUM_UNITS*32  instruction PC.
- cmt_tmask  in  NUM_UNITS*NUM_THREADS  thread mask.
- cmt_wb  in  NUM_UNITS  writeback required.
- cmt_rd  in  NUM_UNITS*5  destination register.
- cmt_data  in  NUM_UNITS*NUM_THREADS*32  per-thread result.
- wb_valid  out  1  writeback valid.
- wb_ready  in  1  writeback accept.
- wb_wid  out  NW_BITS  writeback fields, from the granted unit.
- wb_pc  out  32  writeback fields, from the granted unit.
- wb_tmask  out  NUM_THREADS  writeback fields, from the granted unit.
- wb_rd  out  5  writeback fields, from the granted unit.
- wb_data  out  NUM_THREADS*32  writeback fields, from the granted unit.
- commit_valid  out  1  one-cycle pulse per retired instruction.
- commit_size  out  $clog2(NUM_THREADS)+1  popcount of the retired tmask.
- instret  out  64  cumulative retired-thread count.

Behaviour:
- Reset (synchronous, dominates everything): wb_valid=0; all wb_* fields=0; commit_valid=0; commit_size=0; instret=0; rr pointer=0. In-flight output is discarded.

Handshake:
- Transfer on cmt_valid[i]&&cmt_ready[i]. Producers hold valid and fields until accepted.
- On the wb port, wb_valid and all fields hold stable until wb_valid&&wb_ready.

Slot and eligibility:
- slot_free = !wb_valid || wb_ready.
- eligible[i] = cmt_valid[i] && (!cmt_wb[i] || slot_free).
- wb=0 entries never need the output slot; they can retire while the wb port is stalled.

Arbitration:
- Round-robin over eligible units, starting at the rr pointer.
- At most one grant per cycle. cmt_ready = one-hot grant, combinational.
- After a grant to unit g, the pointer becomes (g+1) mod NUM_UNITS. With no grant, the pointer is unchanged.

Latency, one cycle:
- Granted entry with wb=1 sets wb_valid=1 next cycle and loads the wb_* fields.
- If wb_valid&&wb_ready with no new wb=1 grant, wb_valid clears next cycle.
- A wb=1 grant in the same cycle as wb_ready is allowed: back-to-back throughput is 1/cycle.
- Any grant, wb=0 or wb=1, registers commit_valid=1 next cycle with commit_size=popcount(tmask). Otherwise commit_valid=0 and commit_size is held.
- instret updates in the same cycle as commit_valid: instret += popcount. Wraps modulo 2^64.

Boundary cases:
- tmask=0: still accepted. commit_size=0 and instret is unchanged. If wb=1 the entry is still forwarded with tmask 0.
- rd=0 with wb=1: forwarded unchanged; the regfile ignores x0.
- A wb=1 unit is blocked by a stall while a lower-priority wb=0 unit is valid: the wb=0 unit is granted and the pointer advances past it.
- Non-granted inputs are never consumed; no starvation, since every valid unit is served within NUM_UNITS grants once the slot frees.

Test Plan:
- Reset check: reset high 2 cycles with random inputs -> all outputs 0, cmt_ready=0. First grant after release goes to the lowest valid index.
- Single commit: unit 0 with wb=1, tmask=4'b1011, rd=5, pc=0x80000010, wb_ready=1.
  - Required: cmt_ready[0]=1 in that cycle.
  - Next cycle: wb_valid=1, wb_rd=5, wb_pc=0x80000010, commit_valid=1, commit_size=3, instret=3.
- Fairness: all 6 units valid (wb=1, tmask=4'b1111), wb_ready=1 constantly.
  - Required: grants 0,1,2,3,4,5 on consecutive cycles, wb_valid continuously 1, instret=24 after the sixth.
  - Then unit 0 is re-granted first.
- Backpressure: wb_valid=1 holding unit 1's result, wb_ready=0 for 5 cycles, unit 3 valid with wb=1.
  - Required: cmt_ready=0 and wb_* stable for all 5 cycles.
  - On the cycle wb_ready=1, unit 3 is granted; its data appears next cycle.
- Stall bypass: same stall as above, plus unit 2 valid with wb=0, tmask=4'b1111.
  - Required: unit 2 granted during the stall; commit_valid=1 and commit_size=4 next cycle; wb_* unchanged.
- Mid-operation reset: assert reset while wb_valid=1 and 3 units are pending.
  - Required: next cycle wb_valid=0, instret=0, pointer=0.
  - Pending units are re-arbitrated from index 0 after release.

Source files
------------

// File: rtl/vx_commit_arb.sv
// Commit arbiter: round-robin collects completions from all functional units onto
// one registered writeback port, and produces the retire pulse and instret count.
module vx_commit_arb #(
    parameter int NUM_UNITS   = 6,
    parameter int NUM_THREADS = 4,
    parameter int NW_BITS     = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_UNITS-1:0]                cmt_valid,
    output logic [NUM_UNITS-1:0]                cmt_ready,
    input  logic [NUM_UNITS*NW_BITS-1:0]        cmt_wid,
    input  logic [NUM_UNITS*32-1:0]             cmt_pc,
    input  logic [NUM_UNITS*NUM_THREADS-1:0]    cmt_tmask,
    input  logic [NUM_UNITS-1:0]                cmt_wb,
    input  logic [NUM_UNITS*5-1:0]              cmt_rd,
    input  logic [NUM_UNITS*NUM_THREADS*32-1:0] cmt_data,
    output logic                                wb_valid,
    input  logic                                wb_ready,
    output logic [NW_BITS-1:0]                  wb_wid,
    output logic [31:0]                         wb_pc,
    output logic [NUM_THREADS-1:0]              wb_tmask,
    output logic [4:0]                          wb_rd,
    output logic [NUM_THREADS*32-1:0]           wb_data,
    output logic                                commit_valid,
    output logic [$clog2(NUM_THREADS):0]        commit_size,
    output logic [63:0]                         instret
);
    localparam int PTR_W = $clog2(NUM_UNITS);
    localparam int CS_W  = $clog2(NUM_THREADS) + 1;
    localparam int DW    = NUM_THREADS * 32;

    logic [PTR_W-1:0]       rr_ptr;
    logic                   slot_free;
    logic [NUM_UNITS-1:0]   eligible;
    logic [NUM_UNITS-1:0]   grant;
    logic [PTR_W-1:0]       grant_idx;
    logic                   grant_any;
    logic [PTR_W:0]         cand;

    logic                   sel_wb;
    logic [NW_BITS-1:0]     sel_wid;
    logic [31:0]            sel_pc;
    logic [NUM_THREADS-1:0] sel_tmask;
    logic [4:0]             sel_rd;
    logic [DW-1:0]          sel_data;
    logic [CS_W-1:0]        sel_pop;

    // wb=0 entries never occupy the output slot, so they bypass a stalled port.
    assign slot_free = !wb_valid || wb_ready;
    assign eligible  = cmt_valid & (~cmt_wb | {NUM_UNITS{slot_free}});
    assign cmt_ready = grant;

    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        if (!reset) begin
            for (int k = 0; k < NUM_UNITS; k++) begin
                cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
                if (cand >= (PTR_W+1)'(NUM_UNITS))
                    cand = cand - (PTR_W+1)'(NUM_UNITS);
                if (!grant_any && eligible[cand[PTR_W-1:0]]) begin
                    grant_any                = 1'b1;
                    grant_idx                = cand[PTR_W-1:0];
                    grant[cand[PTR_W-1:0]]   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_wb    = 1'b0;
        sel_wid   = '0;
        sel_pc    = '0;
        sel_tmask = '0;
        sel_rd    = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (grant[i]) begin
                sel_wb    = cmt_wb[i];
                sel_wid   = cmt_wid[i*NW_BITS +: NW_BITS];
                sel_pc    = cmt_pc[i*32 +: 32];
                sel_tmask = cmt_tmask[i*NUM_THREADS +: NUM_THREADS];
                sel_rd    = cmt_rd[i*5 +: 5];
                sel_data  = cmt_data[i*DW +: DW];
            end
        end
        sel_pop = '0;
        for (int t = 0; t < NUM_THREADS; t++)
            sel_pop = sel_pop + CS_W'(sel_tmask[t]);
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid     <= 1'b0;
            wb_wid       <= '0;
            wb_pc        <= '0;
            wb_tmask     <= '0;
            wb_rd        <= '0;
            wb_data      <= '0;
            commit_valid <= 1'b0;
            commit_size  <= '0;
            instret      <= '0;
            rr_ptr       <= '0;
        end else begin
            commit_valid <= grant_any;
            if (grant_any) begin
                commit_size <= sel_pop;
                instret     <= instret + 64'(sel_pop);
                rr_ptr      <= (grant_idx == PTR_W'(NUM_UNITS - 1)) ? '0
                                                                   : grant_idx + PTR_W'(1);
            end
            if (grant_any && sel_wb) begin
                wb_valid <= 1'b1;
                wb_wid   <= sel_wid;
                wb_pc    <= sel_pc;
                wb_tmask <= sel_tmask;
                wb_rd    <= sel_rd;
                wb_data  <= sel_data;
            end else if (wb_ready) begin
                wb_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_vx_commit_arb.sv
// Self-checking bench for vx_commit_arb: directed scenarios plus a randomized run
// checked against a cycle-level behavioural model of the commit/writeback rules.
module tb_vx_commit_arb;
    localparam int NU  = 6;
    localparam int NT  = 4;
    localparam int NWB = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NU-1:0]     cmt_valid, cmt_ready, cmt_wb;
    logic [NU*NWB-1:0] cmt_wid;
    logic [NU*32-1:0]  cmt_pc;
    logic [NU*NT-1:0]  cmt_tmask;
    logic [NU*5-1:0]   cmt_rd;
    logic [NU*NT*32-1:0] cmt_data;
    logic              wb_valid, wb_ready;
    logic [NWB-1:0]    wb_wid;
    logic [31:0]       wb_pc;
    logic [NT-1:0]     wb_tmask;
    logic [4:0]        wb_rd;
    logic [NT*32-1:0]  wb_data;
    logic              commit_valid;
    logic [2:0]        commit_size;
    logic [63:0]       instret;

    vx_commit_arb #(.NUM_UNITS(NU), .NUM_THREADS(NT), .NW_BITS(NWB)) dut (
        .clk(clk), .reset(reset),
        .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_wid(cmt_wid),
        .cmt_pc(cmt_pc), .cmt_tmask(cmt_tmask), .cmt_wb(cmt_wb),
        .cmt_rd(cmt_rd), .cmt_data(cmt_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wid(wb_wid),
        .wb_pc(wb_pc), .wb_tmask(wb_tmask), .wb_rd(wb_rd), .wb_data(wb_data),
        .commit_valid(commit_valid), .commit_size(commit_size), .instret(instret)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Producer-side pending entries, one per unit.
    bit              s_valid [NU];
    bit              s_wb    [NU];
    logic [NWB-1:0]  s_wid   [NU];
    logic [31:0]     s_pc    [NU];
    logic [NT-1:0]   s_tm    [NU];
    logic [4:0]      s_rd    [NU];
    logic [NT*32-1:0] s_data [NU];

    // Reference model state.
    int              m_ptr = 0;
    int              m_grant = -1;
    bit              m_wbv = 0;
    logic [NWB-1:0]  m_wid = '0;
    logic [31:0]     m_pc = '0;
    logic [NT-1:0]   m_tm = '0;
    logic [4:0]      m_rd = '0;
    logic [NT*32-1:0] m_data = '0;
    bit              m_cv = 0;
    logic [2:0]      m_cs = '0;
    logic [63:0]     m_instret = '0;

    task automatic new_entry(input int i, input bit wb, input logic [NT-1:0] tm);
        s_valid[i] = 1'b1;
        s_wb[i]    = wb;
        s_tm[i]    = tm;
        s_wid[i]   = NWB'($urandom);
        s_pc[i]    = $urandom;
        s_rd[i]    = 5'($urandom);
        s_data[i]  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic clear_all();
        for (int i = 0; i < NU; i++) s_valid[i] = 1'b0;
        wb_ready = 1'b1;
    endtask

    // Apply pending entries to the pins, then let the model pick the winner.
    task automatic drive();
        for (int i = 0; i < NU; i++) begin
            cmt_valid[i]             = s_valid[i];
            cmt_wb[i]                = s_wb[i];
            cmt_wid[i*NWB +: NWB]    = s_wid[i];
            cmt_pc[i*32 +: 32]       = s_pc[i];
            cmt_tmask[i*NT +: NT]    = s_tm[i];
            cmt_rd[i*5 +: 5]         = s_rd[i];
            cmt_data[i*NT*32 +: NT*32] = s_data[i];
        end
        #1;
        m_grant = -1;
        if (!reset) begin
            for (int k = 0; k < NU; k++) begin
                int i;
                i = (m_ptr + k) % NU;
                if (m_grant < 0 && s_valid[i] && (!s_wb[i] || !m_wbv || wb_ready))
                    m_grant = i;
            end
        end
    endtask

    // Advance one clock; the model applies the same edge, producers drop accepted entries.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_wbv = 0; m_wid = '0; m_pc = '0; m_tm = '0; m_rd = '0; m_data = '0;
            m_cv = 0; m_cs = '0; m_instret = '0; m_ptr = 0;
        end else begin
            if (m_wbv && wb_ready) m_wbv = 0;
            m_cv = 0;
            if (m_grant >= 0) begin
                int g;
                g = m_grant;
                m_cv = 1;
                m_cs = 3'($countones(s_tm[g]));
                m_instret = m_instret + 64'(m_cs);
                m_ptr = (g + 1) % NU;
                if (s_wb[g]) begin
                    m_wbv = 1; m_wid = s_wid[g]; m_pc = s_pc[g];
                    m_tm = s_tm[g]; m_rd = s_rd[g]; m_data = s_data[g];
                end
                s_valid[g] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int lo;
        reset = 1'b1;
        wb_ready = 1'($urandom);
        for (int i = 0; i < NU; i++) new_entry(i, 1'($urandom), NT'($urandom));
        for (int c = 0; c < 2; c++) begin
            drive();
            total++;
            if (cmt_ready !== 6'b0) begin
                bad++; $display("FAIL reset_ready: got %b want 000000", cmt_ready);
            end
            tick();
            total++;
            if (wb_valid !== 1'b0 || commit_valid !== 1'b0 || commit_size !== 3'd0 ||
                instret !== 64'd0 || wb_pc !== 32'd0 || wb_data !== '0 || wb_rd !== 5'd0) begin
                bad++;
                $display("FAIL reset_outputs: got wbv=%b cv=%b cs=%0d instret=%0d pc=%h want all 0",
                         wb_valid, commit_valid, commit_size, instret, wb_pc);
            end
        end
        reset = 1'b0;
        wb_ready = 1'b1;
        for (int i = 0; i < NU; i++) s_valid[i] = 1'($urandom);
        s_valid[NU-1] = 1'b1;
        lo = NU - 1;
        for (int i = NU - 1; i >= 0; i--) if (s_valid[i]) lo = i;
        drive();
        total++;
        if (cmt_ready !== (6'b1 << lo)) begin
            bad++; $display("FAIL reset_first_grant: got %b want %b", cmt_ready, 6'b1 << lo);
        end
        tick();
        clear_all();
    endtask

    task automatic test_single();
        clear_all();
        do_reset();
        new_entry(0, 1'b1, 4'b1011);
        s_rd[0] = 5'd5;
        s_pc[0] = 32'h8000_0010;
        drive();
        total++;
        if (cmt_ready !== 6'b000001) begin
            bad++; $display("FAIL single_ready: got %b want 000001", cmt_ready);
        end
        tick();
        total++;
        if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_pc !== 32'h8000_0010 ||
            wb_tmask !== 4'b1011 || wb_data !== s_data[0] || wb_wid !== s_wid[0]) begin
            bad++; $display("FAIL single_wb: got v=%b rd=%0d pc=%h tm=%b want 1 5 80000010 1011",
                            wb_valid, wb_rd, wb_pc, wb_tmask);
        end
        total++;
        if (commit_valid !== 1'b1 || commit_size !== 3'd3 || instret !== 64'd3) begin
            bad++; $display("FAIL single_commit: got cv=%b cs=%0d instret=%0d want 1 3 3",
                            commit_valid, commit_size, instret);
        end
        drive();
        tick();
        total++;
        if (wb_valid !== 1'b0 || commit_valid !== 1'b0 || commit_size !== 3'd3 || instret !== 64'd3) begin
            bad++; $display("FAIL single_idle: got wbv=%b cv=%b cs=%0d instret=%0d want 0 0 3 3",
                            wb_valid, commit_valid, commit_size, instret);
        end
    endtask

    task automatic test_fairness();
        clear_all();
        do_reset();
        for (int i = 0; i < NU; i++) new_entry(i, 1'b1, 4'b1111);
        for (int k = 0; k < NU; k++) begin
            drive();
            total++;
            if (cmt_ready !== (6'b1 << k)) begin
                bad++; $display("FAIL fair_grant%0d: got %b want %b", k, cmt_ready, 6'b1 << k);
            end
            tick();
            total++;
            if (wb_valid !== 1'b1 || wb_pc !== s_pc[k] || instret !== 64'(4 * (k + 1))) begin
                bad++; $display("FAIL fair_out%0d: got v=%b pc=%h instret=%0d want 1 %h %0d",
                                k, wb_valid, wb_pc, instret, s_pc[k], 4 * (k + 1));
            end
        end
        for (int i = 0; i < NU; i++) new_entry(i, 1'b1, 4'b1111);
        drive();
        total++;
        if (cmt_ready !== 6'b000001) begin
            bad++; $display("FAIL fair_wrap: got %b want 000001", cmt_ready);
        end
        tick();
        clear_all();
    endtask

    task automatic test_backpressure();
        clear_all();
        do_reset();
        new_entry(1, 1'b1, NT'($urandom));
        drive();
        tick();
        wb_ready = 1'b0;
        new_entry(3, 1'b1, 4'b0110);
        for (int c = 0; c < 5; c++) begin
            drive();
            total++;
            if (cmt_ready !== 6'b0) begin
                bad++; $display("FAIL bp_ready%0d: got %b want 000000", c, cmt_ready);
            end
            tick();
            total++;
            if (wb_valid !== 1'b1 || wb_pc !== s_pc[1] || wb_data !== s_data[1] || wb_rd !== s_rd[1]) begin
                bad++; $display("FAIL bp_hold%0d: got v=%b pc=%h want 1 %h", c, wb_valid, wb_pc, s_pc[1]);
            end
        end
        wb_ready = 1'b1;
        drive();
        total++;
        if (cmt_ready !== 6'b001000) begin
            bad++; $display("FAIL bp_release: got %b want 001000", cmt_ready);
        end
        tick();
        total++;
        if (wb_valid !== 1'b1 || wb_pc !== s_pc[3] || wb_tmask !== 4'b0110) begin
            bad++; $display("FAIL bp_next: got v=%b pc=%h tm=%b want 1 %h 0110",
                            wb_valid, wb_pc, wb_tmask, s_pc[3]);
        end
        clear_all();
        drive();
        tick();
    endtask

    task automatic test_stall_bypass();
        clear_all();
        do_reset();
        new_entry(0, 1'b1, 4'b0001);
        drive();
        tick();
        // Pointer now sits at 1: unit 1 (wb=1) outranks unit 2 (wb=0) but is stalled.
        wb_ready = 1'b0;
        new_entry(1, 1'b1, 4'b0011);
        new_entry(2, 1'b0, 4'b1111);
        new_entry(4, 1'b0, 4'b0000);
        drive();
        total++;
        if (cmt_ready !== 6'b000100) begin
            bad++; $display("FAIL bypass_grant: got %b want 000100", cmt_ready);
        end
        tick();
        total++;
        if (commit_valid !== 1'b1 || commit_size !== 3'd4 || instret !== 64'd5 ||
            wb_valid !== 1'b1 || wb_pc !== s_pc[0]) begin
            bad++; $display("FAIL bypass_commit: got cv=%b cs=%0d instret=%0d pc=%h want 1 4 5 %h",
                            commit_valid, commit_size, instret, wb_pc, s_pc[0]);
        end
        drive();
        total++;
        if (cmt_ready !== 6'b010000) begin
            bad++; $display("FAIL bypass_ptr: got %b want 010000", cmt_ready);
        end
        tick();
        total++;
        if (commit_valid !== 1'b1 || commit_size !== 3'd0 || instret !== 64'd5) begin
            bad++; $display("FAIL bypass_zero_mask: got cv=%b cs=%0d instret=%0d want 1 0 5",
                            commit_valid, commit_size, instret);
        end
        wb_ready = 1'b1;
        drive();
        total++;
        if (cmt_ready !== 6'b000010) begin
            bad++; $display("FAIL bypass_release: got %b want 000010", cmt_ready);
        end
        tick();
        clear_all();
        drive();
        tick();
    endtask

    task automatic test_mid_reset();
        clear_all();
        do_reset();
        new_entry(3, 1'b1, 4'b1111);
        drive();
        tick();
        wb_ready = 1'b0;
        new_entry(1, 1'b1, 4'b0001);
        new_entry(2, 1'b1, 4'b0011);
        new_entry(5, 1'b1, 4'b0111);
        drive();
        tick();
        reset = 1'b1;
        drive();
        total++;
        if (cmt_ready !== 6'b0) begin
            bad++; $display("FAIL midrst_ready: got %b want 000000", cmt_ready);
        end
        tick();
        reset = 1'b0;
        total++;
        if (wb_valid !== 1'b0 || instret !== 64'd0 || commit_valid !== 1'b0 || wb_pc !== 32'd0) begin
            bad++; $display("FAIL midrst_state: got wbv=%b instret=%0d cv=%b pc=%h want 0 0 0 0",
                            wb_valid, instret, commit_valid, wb_pc);
        end
        wb_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            logic [5:0] exp;
            exp = (k == 0) ? 6'b000010 : (k == 1) ? 6'b000100 : 6'b100000;
            drive();
            total++;
            if (cmt_ready !== exp) begin
                bad++; $display("FAIL midrst_order%0d: got %b want %b", k, cmt_ready, exp);
            end
            tick();
        end
        clear_all();
    endtask

    task automatic test_random();
        clear_all();
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            logic [5:0] exp;
            for (int i = 0; i < NU; i++)
                if (!s_valid[i] && $urandom_range(1, 0) == 1)
                    new_entry(i, 1'($urandom), ($urandom_range(7, 0) == 0) ? 4'b0 : NT'($urandom));
            wb_ready = ($urandom_range(2, 0) != 0);
            reset    = ($urandom_range(199, 0) == 0);
            drive();
            exp = (m_grant >= 0) ? (6'b1 << m_grant) : 6'b0;
            total++;
            if (cmt_ready !== exp) begin
                bad++; $display("FAIL rand_ready@%0d: got %b want %b", c, cmt_ready, exp);
            end
            tick();
            total++;
            if (wb_valid !== m_wbv || wb_wid !== m_wid || wb_pc !== m_pc || wb_tmask !== m_tm ||
                wb_rd !== m_rd || wb_data !== m_data) begin
                bad++; $display("FAIL rand_wb@%0d: got v=%b pc=%h rd=%0d want v=%b pc=%h rd=%0d",
                                c, wb_valid, wb_pc, wb_rd, m_wbv, m_pc, m_rd);
            end
            total++;
            if (commit_valid !== m_cv || commit_size !== m_cs || instret !== m_instret) begin
                bad++; $display("FAIL rand_commit@%0d: got cv=%b cs=%0d ir=%0d want cv=%b cs=%0d ir=%0d",
                                c, commit_valid, commit_size, instret, m_cv, m_cs, m_instret);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        wb_ready = 1'b0;
        for (int i = 0; i < NU; i++) begin
            s_valid[i] = 1'b0; s_wb[i] = 1'b0; s_wid[i] = '0; s_pc[i] = '0;
            s_tm[i] = '0; s_rd[i] = '0; s_data[i] = '0;
        end
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_stall_bypass();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
